// File: rtl/bitrev_ctrl.sv
// bitrev_ctrl: ping-pong frame buffer controller; one bank fills in natural order while the
//    other drains in bit-reversed address order into a 2-entry output skid FIFO.
// Ports: clk_i/rst_i (sync, active-high); valid_i/data_i/ready_o sample input;
//    valid_o/data_o/ready_i reordered output; mem_* drive two external banks
//    (read data returns one cycle after mem_re_o); frame_in_o/frame_out_o mark frame ends.
module bitrev_ctrl #(
   parameter int K  = 10,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   output logic          ready_o,
   output logic          valid_o,
   output logic [DW-1:0] data_o,
   input  logic          ready_i,
   output logic          mem_we_o,
   output logic          mem_wbank_o,
   output logic [K-1:0]  mem_waddr_o,
   output logic [DW-1:0] mem_wdata_o,
   output logic          mem_re_o,
   output logic          mem_rbank_o,
   output logic [K-1:0]  mem_raddr_o,
   input  logic [DW-1:0] mem_rdata_i,
   output logic          frame_in_o,
   output logic          frame_out_o
);

   localparam logic [K-1:0] CNT_LAST = '1;

   typedef enum logic [1:0] {
      B_EMPTY    = 2'd0,
      B_FILLING  = 2'd1,
      B_FULL     = 2'd2,
      B_DRAINING = 2'd3
   } bank_st_e;

   bank_st_e      st_q [2];
   bank_st_e      st_d [2];
   logic          wbank_q, wbank_d;
   logic          rbank_q, rbank_d;
   logic [K-1:0]  wcnt_q, wcnt_d;
   logic [K-1:0]  rcnt_q, rcnt_d;
   logic [K-1:0]  ocnt_q, ocnt_d;
   logic [1:0]    occ_q, occ_d;
   logic          infl_q;
   logic          run_q;
   logic          fwp_q, frp_q;
   logic [DW-1:0] fifo_q [2];

   logic          active, wr_open, rd_open, credit;
   logic          wr_hs, rd_iss, pop, push;
   logic          wr_last, rd_last;
   logic [K-1:0]  raddr;

   // ---------------- state register ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q[0] <= B_EMPTY;
         st_q[1] <= B_EMPTY;
         wbank_q <= 1'b0;
         rbank_q <= 1'b0;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
         ocnt_q  <= '0;
         occ_q   <= '0;
         infl_q  <= 1'b0;
         run_q   <= 1'b0;
         fwp_q   <= 1'b0;
         frp_q   <= 1'b0;
      end else begin
         st_q[0] <= st_d[0];
         st_q[1] <= st_d[1];
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         ocnt_q  <= ocnt_d;
         occ_q   <= occ_d;
         infl_q  <= rd_iss;
         run_q   <= 1'b1;
         fwp_q   <= fwp_q ^ push;
         frp_q   <= frp_q ^ pop;
      end
   end

   // FIFO storage needs no reset: data_o is masked whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_q[fwp_q] <= mem_rdata_i;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      st_d[0] = st_q[0];
      st_d[1] = st_q[1];
      // Writer and reader always point at different banks whenever both are
      // active, so these two updates never target the same entry.
      if (wr_hs) begin
         st_d[wbank_q] = wr_last ? B_FULL : B_FILLING;
      end
      if (rd_iss) begin
         st_d[rbank_q] = rd_last ? B_EMPTY : B_DRAINING;
      end
      wbank_d = wbank_q ^ (wr_hs & wr_last);
      rbank_d = rbank_q ^ (rd_iss & rd_last);
      wcnt_d  = wr_hs  ? wcnt_q + K'(1) : wcnt_q;
      rcnt_d  = rd_iss ? rcnt_q + K'(1) : rcnt_q;
      ocnt_d  = pop    ? ocnt_q + K'(1) : ocnt_q;
      occ_d   = occ_q + {1'b0, push} - {1'b0, pop};
   end

   // ---------------- output logic ----------------
   always_comb begin
      // run_q holds everything quiet for the first cycle after reset release.
      active  = run_q & ~rst_i;
      wr_open = (st_q[wbank_q] == B_EMPTY) || (st_q[wbank_q] == B_FILLING);
      rd_open = (st_q[rbank_q] == B_FULL)  || (st_q[rbank_q] == B_DRAINING);
      wr_last = (wcnt_q == CNT_LAST);
      rd_last = (rcnt_q == CNT_LAST);

      valid_o = active & (occ_q != 2'd0);
      pop     = valid_o & ready_i;
      push    = infl_q;
      // A read is issued only if its data is guaranteed a FIFO slot when it lands.
      credit  = ({1'b0, occ_q} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop});

      ready_o = active & wr_open;
      wr_hs   = valid_i & ready_o;
      rd_iss  = active & rd_open & credit;

      raddr = '0;
      for (int i = 0; i < K; i++) begin
         raddr[i] = rcnt_q[K-1-i];
      end

      data_o      = valid_o ? fifo_q[frp_q] : '0;
      mem_we_o    = wr_hs;
      mem_wbank_o = wbank_q;
      mem_waddr_o = wcnt_q;
      mem_wdata_o = data_i;
      mem_re_o    = rd_iss;
      mem_rbank_o = rbank_q;
      mem_raddr_o = raddr;
      frame_in_o  = wr_hs & wr_last;
      frame_out_o = pop & (ocnt_q == CNT_LAST);
   end

endmodule
